// File: rtl/pt2262_frame_tx.sv
// rtl/pt2262_frame_tx.sv - PT2262-compatible tri-state frame encoder with repeat and stop control
module pt2262_frame_tx #(
    parameter int NTRITS = 12,
    parameter int DIV_W  = 16,
    parameter int REP_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*NTRITS-1:0]   code,
    input  logic [DIV_W-1:0]      div,
    input  logic [REP_W-1:0]      repeats,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic                  q
);

    // Trit index width; a single-trit frame still needs a one-bit index.
    localparam int TW = (NTRITS > 1) ? $clog2(NTRITS) : 1;
    localparam logic [TW-1:0] LAST_TRIT = TW'(NTRITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIT,
        ST_SYNC,
        ST_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [2*NTRITS-1:0]   code_q, code_d;
    logic [DIV_W-1:0]      div_l_q, div_l_d;
    logic [REP_W-1:0]      rep_q, rep_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [6:0]            alpha_q, alpha_d;
    logic [TW-1:0]         trit_q, trit_d;
    logic [REP_W-1:0]      frame_q, frame_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  q_q, q_d;

    logic                  tick;
    logic [2*NTRITS-1:0]   code_sh;
    logic [1:0]            trit_sel;
    logic [3:0]            hi_len;

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;

    // One alpha unit elapses on the last clk of each divider period.
    assign tick = (div_cnt_q == (div_l_q - DIV_W'(1)));

    // State register plus all counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            div_l_q     <= '0;
            rep_q       <= '0;
            div_cnt_q   <= '0;
            alpha_q     <= '0;
            trit_q      <= '0;
            frame_q     <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            q_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            div_l_q     <= div_l_d;
            rep_q       <= rep_d;
            div_cnt_q   <= div_cnt_d;
            alpha_q     <= alpha_d;
            trit_q      <= trit_d;
            frame_q     <= frame_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            q_q         <= q_d;
        end
    end

    // Next-state sequencing: operand latch, alpha divider, trit/sync/frame counting.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        div_l_d     = div_l_q;
        rep_d       = rep_q;
        div_cnt_d   = div_cnt_q;
        alpha_d     = alpha_q;
        trit_d      = trit_q;
        frame_d     = frame_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    code_d      = code;
                    div_l_d     = (div == '0) ? DIV_W'(1) : div;
                    rep_d       = repeats;
                    div_cnt_d   = '0;
                    alpha_d     = '0;
                    trit_d      = LAST_TRIT;
                    frame_d     = '0;
                    stop_pend_d = 1'b0;
                    state_d     = ST_TRIT;
                end
            end

            ST_TRIT: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tick) begin
                    div_cnt_d = '0;
                    if (alpha_q == 7'd31) begin
                        alpha_d = '0;
                        if (trit_q == '0) begin
                            state_d = ST_SYNC;
                        end else begin
                            trit_d = trit_q - TW'(1);
                        end
                    end else begin
                        alpha_d = alpha_q + 7'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            ST_SYNC: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tick) begin
                    div_cnt_d = '0;
                    if (alpha_q == 7'd127) begin
                        alpha_d = '0;
                        // Frame counter never passes repeats, so all-ones cannot wrap.
                        if ((frame_q == rep_q) || stop_pend_q || stop) begin
                            state_d = ST_FINISH;
                        end else begin
                            frame_d = frame_q + REP_W'(1);
                            trit_d  = LAST_TRIT;
                            state_d = ST_TRIT;
                        end
                    end else begin
                        alpha_d = alpha_q + 7'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            ST_FINISH: begin
                stop_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so q, busy and done are plain flops.
    always_comb begin
        code_sh  = code_d >> {trit_d, 1'b0};
        trit_sel = code_sh[1:0];
        hi_len   = 4'd4;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        q_d      = 1'b0;

        case (trit_sel)
            2'b00:   hi_len = 4'd4;
            2'b11:   hi_len = 4'd12;
            default: hi_len = alpha_d[4] ? 4'd12 : 4'd4;
        endcase

        case (state_d)
            ST_TRIT: begin
                busy_d = 1'b1;
                q_d    = (alpha_d[3:0] < hi_len);
            end
            ST_SYNC: begin
                busy_d = 1'b1;
                q_d    = (alpha_d < 7'd4);
            end
            ST_FINISH: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pt2262_frame_tx.sv
// tb/tb_pt2262_frame_tx.sv - directed self-checking bench for pt2262_frame_tx
module tb_pt2262_frame_tx;

    logic        clk;
    logic        reset;
    logic [23:0] code;
    logic [15:0] div;
    logic [3:0]  repeats;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        q;

    int checks;
    int errors;

    logic qb [0:2199];
    logic bb [0:2199];
    logic db [0:2199];

    pt2262_frame_tx #(.NTRITS(12), .DIV_W(16), .REP_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .code    (code),
        .div     (div),
        .repeats (repeats),
        .start   (start),
        .stop    (stop),
        .busy    (busy),
        .done    (done),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected q at alpha position p (0..511) of a 12-trit frame.
    function automatic logic exp_q(input logic [23:0] c, input int p);
        int t, a, hi;
        logic [23:0] sh;
        logic [1:0] tr;
        if (p >= 384) return ((p - 384) < 4);
        t  = 11 - p / 32;
        a  = p % 32;
        sh = c >> (2 * t);
        tr = sh[1:0];
        if (tr == 2'b00)      hi = 4;
        else if (tr == 2'b11) hi = 12;
        else                  hi = (a >= 16) ? 12 : 4;
        return ((a % 16) < hi);
    endfunction

    // First captured cycle in 1..upto whose q differs from the model; 0 if none.
    function automatic int first_bad(input logic [23:0] c, input int divl, input int frames, input int upto);
        logic e;
        for (int j = 1; j <= upto; j++) begin
            e = (j <= frames * 512 * divl) ? exp_q(c, ((j - 1) / divl) % 512) : 1'b0;
            if (qb[j] !== e) return j;
        end
        return 0;
    endfunction

    function automatic int count_busy(input int upto);
        int n;
        n = 0;
        for (int j = 1; j <= upto; j++) if (bb[j] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_done(input int upto);
        int n;
        n = 0;
        for (int j = 1; j <= upto; j++) if (db[j] === 1'b1) n++;
        return n;
    endfunction

    // Pulse start with the given operands and record ncyc cycles after the start edge.
    task automatic capture(input logic [23:0] c, input logic [15:0] d, input logic [3:0] r,
                           input int ncyc, input int stop_at, input int start_at,
                           input logic [23:0] c2, input int reset_at, input bit hold_start);
        code    = c;
        div     = d;
        repeats = r;
        start   = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        for (int j = 1; j <= ncyc; j++) begin
            qb[j] = q;
            bb[j] = busy;
            db[j] = done;
            stop  = (j == stop_at);
            reset = (j == reset_at);
            if (j == start_at) begin
                start = 1'b1;
                code  = c2;
            end else if (!hold_start) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        code = '0; div = 16'd1; repeats = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (q !== 1'b0)    begin errors++; $display("FAIL reset_q: got %b want 0", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        // stop while idle must not affect anything
        stop = 1'b1; @(posedge clk); #1 stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_stop_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic;
        int b;
        capture(24'h000000, 16'd1, 4'd0, 530, -1, -1, 24'h0, -1, 1'b0);
        b = first_bad(24'h000000, 1, 1, 530);
        checks++; if (b != 0) begin errors++; $display("FAIL basic_wave: cycle %0d got %b want %b", b, qb[b], ~qb[b]); end
        checks++; if (qb[1] !== 1'b1 || qb[4] !== 1'b1 || qb[5] !== 1'b0 || qb[16] !== 1'b0 || qb[17] !== 1'b1)
            begin errors++; $display("FAIL basic_first_trit: got %b%b%b%b%b want 11001", qb[1], qb[4], qb[5], qb[16], qb[17]); end
        checks++; if (qb[388] !== 1'b1 || qb[389] !== 1'b0 || qb[512] !== 1'b0)
            begin errors++; $display("FAIL basic_sync: got %b%b%b want 100", qb[388], qb[389], qb[512]); end
        checks++; if (count_busy(530) != 512) begin errors++; $display("FAIL basic_busy_len: got %0d want 512", count_busy(530)); end
        checks++; if (bb[1] !== 1'b1 || bb[512] !== 1'b1 || bb[513] !== 1'b0)
            begin errors++; $display("FAIL basic_busy_edges: got %b%b%b want 110", bb[1], bb[512], bb[513]); end
        checks++; if (db[513] !== 1'b1 || count_done(530) != 1)
            begin errors++; $display("FAIL basic_done: got done513=%b count=%0d want 1 1", db[513], count_done(530)); end
    endtask

    task automatic test_div3;
        int run_len [8] = '{36, 12, 36, 12, 12, 36, 36, 12};
        logic run_lvl [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int j, bad, b;
        capture(24'hD00000, 16'd3, 4'd0, 1540, -1, -1, 24'h0, -1, 1'b0);
        j = 1; bad = 0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < run_len[r]; k++) begin
                if (bad == 0 && qb[j] !== run_lvl[r]) bad = j;
                j++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL div3_runs: cycle %0d got %b want %b", bad, qb[bad], ~qb[bad]); end
        b = first_bad(24'hD00000, 3, 1, 1540);
        checks++; if (b != 0) begin errors++; $display("FAIL div3_wave: cycle %0d got %b want %b", b, qb[b], ~qb[b]); end
        checks++; if (count_busy(1540) != 1536) begin errors++; $display("FAIL div3_busy_len: got %0d want 1536", count_busy(1540)); end
        checks++; if (db[1537] !== 1'b1) begin errors++; $display("FAIL div3_done: got %b want 1", db[1537]); end
    endtask

    task automatic test_repeats;
        int b;
        capture(24'h5A3C0F, 16'd1, 4'd2, 1545, -1, -1, 24'h0, -1, 1'b0);
        b = first_bad(24'h5A3C0F, 1, 3, 1545);
        checks++; if (b != 0) begin errors++; $display("FAIL rep_wave: cycle %0d got %b want %b", b, qb[b], ~qb[b]); end
        checks++; if (count_busy(1545) != 1536) begin errors++; $display("FAIL rep_busy_len: got %0d want 1536", count_busy(1545)); end
        checks++; if (count_done(1545) != 1 || db[1537] !== 1'b1)
            begin errors++; $display("FAIL rep_done: got count=%0d done1537=%b want 1 1", count_done(1545), db[1537]); end
        // div=0 behaves as div=1
        capture(24'h5A3C0F, 16'd0, 4'd0, 520, -1, -1, 24'h0, -1, 1'b0);
        b = first_bad(24'h5A3C0F, 1, 1, 520);
        checks++; if (b != 0) begin errors++; $display("FAIL div0_wave: cycle %0d got %b want %b", b, qb[b], ~qb[b]); end
        checks++; if (count_busy(520) != 512 || db[513] !== 1'b1)
            begin errors++; $display("FAIL div0_timing: got busy=%0d done513=%b want 512 1", count_busy(520), db[513]); end
    endtask

    task automatic test_stop;
        int b;
        capture(24'hFFF000, 16'd1, 4'd5, 1100, 100, -1, 24'h0, -1, 1'b0);
        b = first_bad(24'hFFF000, 1, 1, 1100);
        checks++; if (b != 0) begin errors++; $display("FAIL stop_wave: cycle %0d got %b want %b", b, qb[b], ~qb[b]); end
        checks++; if (count_busy(1100) != 512) begin errors++; $display("FAIL stop_busy_len: got %0d want 512", count_busy(1100)); end
        checks++; if (db[513] !== 1'b1 || count_done(1100) != 1)
            begin errors++; $display("FAIL stop_done: got done513=%b count=%0d want 1 1", db[513], count_done(1100)); end
    endtask

    task automatic test_ignore_start;
        int b;
        capture(24'hC3A500, 16'd1, 4'd0, 530, -1, 50, 24'hFFFFFF, -1, 1'b0);
        b = first_bad(24'hC3A500, 1, 1, 530);
        checks++; if (b != 0) begin errors++; $display("FAIL ignore_wave: cycle %0d got %b want %b", b, qb[b], ~qb[b]); end
        checks++; if (count_busy(530) != 512) begin errors++; $display("FAIL ignore_busy_len: got %0d want 512", count_busy(530)); end
    endtask

    task automatic test_reset_mid;
        int b;
        capture(24'h123456, 16'd1, 4'd3, 800, -1, -1, 24'h0, 200, 1'b0);
        checks++; if (qb[201] !== 1'b0 || bb[201] !== 1'b0)
            begin errors++; $display("FAIL rstmid_outputs: got q=%b busy=%b want 0 0", qb[201], bb[201]); end
        checks++; if (count_done(800) != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", count_done(800)); end
        checks++; if (count_busy(800) != 200) begin errors++; $display("FAIL rstmid_busy_len: got %0d want 200", count_busy(800)); end
        capture(24'h123456, 16'd1, 4'd0, 520, -1, -1, 24'h0, -1, 1'b0);
        b = first_bad(24'h123456, 1, 1, 520);
        checks++; if (b != 0) begin errors++; $display("FAIL rstmid_restart_wave: cycle %0d got %b want %b", b, qb[b], ~qb[b]); end
        checks++; if (db[513] !== 1'b1) begin errors++; $display("FAIL rstmid_restart_done: got %b want 1", db[513]); end
    endtask

    task automatic test_back_to_back;
        // start held high: ignored while busy and in FINISH, accepted from IDLE after
        capture(24'h000000, 16'd1, 4'd0, 600, -1, -1, 24'h0, -1, 1'b1);
        checks++; if (db[513] !== 1'b1 || bb[513] !== 1'b0)
            begin errors++; $display("FAIL b2b_finish: got done=%b busy=%b want 1 0", db[513], bb[513]); end
        checks++; if (bb[514] !== 1'b0 || db[514] !== 1'b0)
            begin errors++; $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", bb[514], db[514]); end
        checks++; if (bb[515] !== 1'b1 || qb[515] !== 1'b1)
            begin errors++; $display("FAIL b2b_restart: got busy=%b q=%b want 1 1", bb[515], qb[515]); end
        // let the second frame drain
        repeat (520) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy=%b want 0", busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        code = '0; div = '0; repeats = '0;
        test_reset;
        test_basic;
        test_div3;
        test_repeats;
        test_stop;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
